// File: rtl/mem_arbiter_pkg.sv
// Shared types for the two-master memory front end: FSM states, owner
// encoding, request bundle and the read-abort data pattern.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_WAIT_RD = 2'd2
    } state_e;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_LS = 1'b1
    } owner_e;

    typedef struct packed {
        logic        cs;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  byte_en;
        logic        read_en;
        logic        write_en;
    } mc_req_t;

    localparam logic [31:0] ERR_DATA = 32'hDEAD_BEEF;

    function automatic logic addr_in_region(
        input logic [31:0] addr,
        input logic [31:0] base,
        input logic [31:0] mask
    );
        return ((addr & mask) == base);
    endfunction

endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// Two-request round-robin arbiter; on contention the master that did not win
// last time is granted. last_grant only moves when a grant is actually made.
module rr_arb2
    import mem_arbiter_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic i_en,
    input  logic i_req_if,
    input  logic i_req_ls,
    output logic o_gnt_if,
    output logic o_gnt_ls
);

    owner_e r_last_grant;

    always_comb begin
        o_gnt_if = 1'b0;
        o_gnt_ls = 1'b0;
        if (i_en) begin
            if (i_req_if && i_req_ls) begin
                if (r_last_grant == OWN_IF) begin
                    o_gnt_ls = 1'b1;
                end else begin
                    o_gnt_if = 1'b1;
                end
            end else if (i_req_if) begin
                o_gnt_if = 1'b1;
            end else if (i_req_ls) begin
                o_gnt_ls = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last_grant <= OWN_IF;
        end else if (o_gnt_if) begin
            r_last_grant <= OWN_IF;
        end else if (o_gnt_ls) begin
            r_last_grant <= OWN_LS;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-master (IF / LS) front end for the memory controller: arbitrates,
// decodes the data-RAM chip select and routes read data back to the owner.
//
//   state      | meaning
//   -----------+----------------------------------------------------------
//   ST_IDLE    | no transaction; combinational grant to a requesting master
//   ST_REQ     | latched request presented to the controller until accepted
//   ST_WAIT_RD | read accepted, waiting for data or the timeout
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter logic [31:0] DATA_BASE = 32'h0001_0000,
    parameter logic [31:0] DATA_MASK = 32'hFFFF_0000,
    parameter int          TIMEOUT   = 16
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        if_req_valid,
    input  logic [31:0] if_addr,
    output logic        if_req_ready,
    output logic        if_rdata_valid,
    output logic [31:0] if_rdata,
    output logic        if_err,

    input  logic        ls_req_valid,
    input  logic        ls_we,
    input  logic [31:0] ls_addr,
    input  logic [31:0] ls_wdata,
    input  logic [3:0]  ls_byte_en,
    output logic        ls_req_ready,
    output logic        ls_rdata_valid,
    output logic [31:0] ls_rdata,
    output logic        ls_err,

    output logic        mc_valid_out,
    input  logic        mc_ready_in,
    output logic        mc_cs_out,
    output logic [31:0] mc_addr_out,
    output logic [31:0] mc_write_data_out,
    output logic [3:0]  mc_write_byte_en_out,
    output logic        mc_read_en_out,
    output logic        mc_write_en_out,
    input  logic        mc_rdata_valid_in,
    input  logic [31:0] mc_read_data_in
);

    localparam int              CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_e           r_state;
    state_e           w_next_state;
    owner_e           r_owner;
    mc_req_t          r_req;
    mc_req_t          w_req_new;
    logic [CNT_W-1:0] r_cnt;

    logic        r_if_rdata_valid;
    logic [31:0] r_if_rdata;
    logic        r_if_err;
    logic        r_ls_rdata_valid;
    logic [31:0] r_ls_rdata;
    logic        r_ls_err;

    logic w_arb_en;
    logic w_grant_if;
    logic w_grant_ls;
    logic w_ls_cs;
    logic w_ls_bad_wr;
    logic w_load_req;
    logic w_done_data;
    logic w_done_timeout;
    logic w_cnt_clr;
    logic w_cnt_inc;

    // Gating with rst keeps the ready outputs low while reset is held.
    assign w_arb_en = (r_state == ST_IDLE) && !rst;

    rr_arb2 u_arb (
        .clk      (clk),
        .rst      (rst),
        .i_en     (w_arb_en),
        .i_req_if (if_req_valid),
        .i_req_ls (ls_req_valid),
        .o_gnt_if (w_grant_if),
        .o_gnt_ls (w_grant_ls)
    );

    assign w_ls_cs     = addr_in_region(ls_addr, DATA_BASE, DATA_MASK);
    assign w_ls_bad_wr = w_grant_ls && ls_we && !w_ls_cs;

    always_comb begin
        w_req_new = '0;
        if (w_grant_if) begin
            w_req_new.cs       = 1'b0;
            w_req_new.addr     = if_addr;
            w_req_new.byte_en  = 4'hF;
            w_req_new.read_en  = 1'b1;
        end else begin
            w_req_new.cs       = w_ls_cs;
            w_req_new.addr     = ls_addr;
            w_req_new.wdata    = ls_wdata;
            w_req_new.byte_en  = ls_byte_en;
            w_req_new.read_en  = !ls_we;
            w_req_new.write_en = ls_we;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state   = r_state;
        w_load_req     = 1'b0;
        w_done_data    = 1'b0;
        w_done_timeout = 1'b0;
        w_cnt_clr      = 1'b0;
        w_cnt_inc      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_grant_if || (w_grant_ls && !w_ls_bad_wr)) begin
                    w_load_req   = 1'b1;
                    w_next_state = ST_REQ;
                end
            end
            ST_REQ: begin
                if (mc_ready_in) begin
                    if (r_req.write_en) begin
                        w_next_state = ST_IDLE;
                    end else if (mc_rdata_valid_in) begin
                        w_done_data  = 1'b1;
                        w_next_state = ST_IDLE;
                    end else begin
                        w_cnt_clr    = 1'b1;
                        w_next_state = ST_WAIT_RD;
                    end
                end
            end
            ST_WAIT_RD: begin
                if (mc_rdata_valid_in) begin
                    w_done_data  = 1'b1;
                    w_next_state = ST_IDLE;
                end else if (r_cnt == CNT_LAST) begin
                    w_done_timeout = 1'b1;
                    w_next_state   = ST_IDLE;
                end else begin
                    w_cnt_inc = 1'b1;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_owner          <= OWN_IF;
            r_req            <= '0;
            r_cnt            <= '0;
            r_if_rdata_valid <= 1'b0;
            r_if_rdata       <= '0;
            r_if_err         <= 1'b0;
            r_ls_rdata_valid <= 1'b0;
            r_ls_rdata       <= '0;
            r_ls_err         <= 1'b0;
        end else begin
            r_if_rdata_valid <= 1'b0;
            r_if_err         <= 1'b0;
            r_ls_rdata_valid <= 1'b0;
            r_ls_err         <= 1'b0;

            if (w_load_req) begin
                r_req   <= w_req_new;
                r_owner <= w_grant_ls ? OWN_LS : OWN_IF;
            end

            // Writes into the instruction region are refused without touching the controller.
            if (w_ls_bad_wr) begin
                r_ls_err <= 1'b1;
            end

            if (w_cnt_clr) begin
                r_cnt <= '0;
            end else if (w_cnt_inc) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end

            if (w_done_data) begin
                if (r_owner == OWN_IF) begin
                    r_if_rdata       <= mc_read_data_in;
                    r_if_rdata_valid <= 1'b1;
                end else begin
                    r_ls_rdata       <= mc_read_data_in;
                    r_ls_rdata_valid <= 1'b1;
                end
            end else if (w_done_timeout) begin
                if (r_owner == OWN_IF) begin
                    r_if_rdata <= ERR_DATA;
                    r_if_err   <= 1'b1;
                end else begin
                    r_ls_rdata <= ERR_DATA;
                    r_ls_err   <= 1'b1;
                end
            end
        end
    end

    assign if_req_ready         = w_grant_if;
    assign ls_req_ready         = w_grant_ls;
    assign if_rdata_valid       = r_if_rdata_valid;
    assign if_rdata             = r_if_rdata;
    assign if_err               = r_if_err;
    assign ls_rdata_valid       = r_ls_rdata_valid;
    assign ls_rdata             = r_ls_rdata;
    assign ls_err               = r_ls_err;

    assign mc_valid_out         = (r_state == ST_REQ);
    assign mc_cs_out            = r_req.cs;
    assign mc_addr_out          = r_req.addr;
    assign mc_write_data_out    = r_req.wdata;
    assign mc_write_byte_en_out = r_req.byte_en;
    assign mc_read_en_out       = r_req.read_en;
    assign mc_write_en_out      = r_req.write_en;

endmodule
